alu_ctrl_scoreboard: RTL and testbench

//  Next-gen ALU decoder: pipelined, handshaked decode of ALUOp/FUNCT/ShiftType into ALUControl/FlagW.

---
 rtl/alu_ctrl_pkg.sv | 86 ++++++++
 rtl/alu_ctrl_scoreboard_flag_fifo.sv | 66 ++++++
 rtl/alu_ctrl_scoreboard.sv | 174 +++++++++++++++++
 tb/tb_alu_ctrl_scoreboard.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctrl_pkg
// Description : Shared constants for the ALU control scoreboard: ALUControl
//               codes, FUNCT opcodes, shift types, condition codes, FlagW
//               encodings and the NZCV condition evaluator.
// Revision    : 1.0  initial release
// ============================================================================
package alu_ctrl_pkg;

    // ALUControl operation codes
    localparam logic [3:0] c_alu_add = 4'b0000;
    localparam logic [3:0] c_alu_sub = 4'b0001;
    localparam logic [3:0] c_alu_cmp = 4'b0010;
    localparam logic [3:0] c_alu_and = 4'b0011;
    localparam logic [3:0] c_alu_orr = 4'b0100;
    localparam logic [3:0] c_alu_lsr = 4'b0101;
    localparam logic [3:0] c_alu_lsl = 4'b0110;
    localparam logic [3:0] c_alu_asr = 4'b0111;
    localparam logic [3:0] c_alu_ror = 4'b1000;
    localparam logic [3:0] c_alu_eor = 4'b1001;

    // FUNCT[4:1] opcodes
    localparam logic [3:0] c_op_add = 4'b0100;
    localparam logic [3:0] c_op_sub = 4'b0010;
    localparam logic [3:0] c_op_cmp = 4'b1010;
    localparam logic [3:0] c_op_and = 4'b0000;
    localparam logic [3:0] c_op_orr = 4'b1100;
    localparam logic [3:0] c_op_shf = 4'b1101;
    localparam logic [3:0] c_op_eor = 4'b0001;

    // Shift types
    localparam logic [1:0] c_sh_lsl = 2'b00;
    localparam logic [1:0] c_sh_lsr = 2'b01;
    localparam logic [1:0] c_sh_asr = 2'b10;
    localparam logic [1:0] c_sh_ror = 2'b11;

    // Condition codes
    localparam logic [3:0] c_cond_eq = 4'b0000;
    localparam logic [3:0] c_cond_ne = 4'b0001;
    localparam logic [3:0] c_cond_cs = 4'b0010;
    localparam logic [3:0] c_cond_cc = 4'b0011;
    localparam logic [3:0] c_cond_mi = 4'b0100;
    localparam logic [3:0] c_cond_pl = 4'b0101;
    localparam logic [3:0] c_cond_vs = 4'b0110;
    localparam logic [3:0] c_cond_vc = 4'b0111;
    localparam logic [3:0] c_cond_hi = 4'b1000;
    localparam logic [3:0] c_cond_ls = 4'b1001;
    localparam logic [3:0] c_cond_ge = 4'b1010;
    localparam logic [3:0] c_cond_lt = 4'b1011;
    localparam logic [3:0] c_cond_gt = 4'b1100;
    localparam logic [3:0] c_cond_le = 4'b1101;
    localparam logic [3:0] c_cond_al = 4'b1110;
    localparam logic [3:0] c_cond_nv = 4'b1111;

    // FlagW encodings: [1] writes NZ, [0] writes CV
    localparam logic [1:0] c_fw_none = 2'b00;
    localparam logic [1:0] c_fw_nz   = 2'b10;
    localparam logic [1:0] c_fw_all  = 2'b11;

    // Evaluate an ARM condition field against {N,Z,C,V}; NV never passes
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        {n, z, c, v} = nzcv;
        case (cond)
            c_cond_eq: cond_pass = z;
            c_cond_ne: cond_pass = ~z;
            c_cond_cs: cond_pass = c;
            c_cond_cc: cond_pass = ~c;
            c_cond_mi: cond_pass = n;
            c_cond_pl: cond_pass = ~n;
            c_cond_vs: cond_pass = v;
            c_cond_vc: cond_pass = ~v;
            c_cond_hi: cond_pass = c & ~z;
            c_cond_ls: cond_pass = ~c | z;
            c_cond_ge: cond_pass = (n == v);
            c_cond_lt: cond_pass = (n != v);
            c_cond_gt: cond_pass = ~z & (n == v);
            c_cond_le: cond_pass = z | (n != v);
            c_cond_al: cond_pass = 1'b1;
            default:   cond_pass = 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_ctrl_scoreboard_flag_fifo.sv
`default_nettype none
// ============================================================================
// Module      : flag_fifo
// Description : 2-bit-wide synchronous FIFO holding the FlagW masks of
//               in-flight flag writers. Push while full is accepted only
//               when a pop happens in the same cycle.
// Revision    : 1.0  initial release
// ============================================================================
module flag_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [1:0]               i_wdata,
    input  logic                     i_pop,
    output logic [1:0]               o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] c_full_count = (AW+1)'(DEPTH);

    logic [1:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_count == c_full_count);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rptr];
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    // Storage and pointer/count update; reset discards every entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 2'b00;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wptr] <= i_wdata;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_ctrl_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctrl_scoreboard
// Description : Pipelined, handshaked ALU decoder. Decodes ALUOp/FUNCT/
//               ShiftType into ALUControl/FlagW, owns the NZCV register,
//               evaluates the condition field and stalls conditional
//               instructions until all in-flight flag writers have retired.
// Revision    : 1.0  initial release
// ============================================================================
module alu_ctrl_scoreboard
    import alu_ctrl_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int CTRL_W  = 4,
    parameter int EXT_OPS = 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic              ALUOp,
    input  logic [4:0]        FUNCT,
    input  logic [1:0]        ShiftType,
    input  logic [3:0]        Cond,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [CTRL_W-1:0] ALUControl,
    output logic [1:0]        FlagW,
    output logic              CondEx,
    output logic              ILLEGAL,
    input  logic              FLAG_VALID,
    input  logic [3:0]        ALUFlags,
    output logic [3:0]        FLAGS,
    output logic              FLAG_ERR
);

    localparam int c_aw = $clog2(DEPTH);
    localparam logic c_ext = (EXT_OPS != 0);

    logic              r_out_valid;
    logic [CTRL_W-1:0] r_ctrl;
    logic [1:0]        r_flagw;
    logic              r_condex;
    logic              r_illegal;
    logic [3:0]        r_flags;
    logic              r_flag_err;

    logic [3:0]  w_op;
    logic [1:0]  w_fw_raw;
    logic        w_legal;
    logic        w_pass;
    logic [3:0]  w_ctrl;
    logic [1:0]  w_fw;
    logic        w_condex;
    logic        w_illegal;
    logic        w_slot_free;
    logic        w_hazard;
    logic        w_accept;
    logic        w_push;
    logic        w_pop;
    logic [1:0]  w_fifo_head;
    logic        w_fifo_full;
    logic        w_fifo_empty;
    logic [c_aw:0] w_fifo_count;

    // Decode opcode/shift and evaluate the condition against the current NZCV
    always_comb begin
        w_op     = c_alu_add;
        w_fw_raw = c_fw_none;
        w_legal  = 1'b1;
        w_pass   = 1'b1;
        if (ALUOp) begin
            case (FUNCT[4:1])
                c_op_add: begin w_op = c_alu_add; w_fw_raw = FUNCT[0] ? c_fw_all : c_fw_none; end
                c_op_sub: begin w_op = c_alu_sub; w_fw_raw = FUNCT[0] ? c_fw_all : c_fw_none; end
                c_op_cmp: begin w_op = c_alu_cmp; w_fw_raw = c_fw_all; end
                c_op_and: begin w_op = c_alu_and; w_fw_raw = FUNCT[0] ? c_fw_nz : c_fw_none; end
                c_op_orr: begin w_op = c_alu_orr; w_fw_raw = FUNCT[0] ? c_fw_nz : c_fw_none; end
                c_op_eor: begin
                    w_op     = c_alu_eor;
                    w_fw_raw = FUNCT[0] ? c_fw_nz : c_fw_none;
                    w_legal  = c_ext;
                end
                c_op_shf: begin
                    w_fw_raw = FUNCT[0] ? c_fw_nz : c_fw_none;
                    case (ShiftType)
                        c_sh_lsl: w_op = c_alu_lsl;
                        c_sh_lsr: w_op = c_alu_lsr;
                        c_sh_asr: begin w_op = c_alu_asr; w_legal = c_ext; end
                        c_sh_ror: begin w_op = c_alu_ror; w_legal = c_ext; end
                    endcase
                end
                default: w_legal = 1'b0;
            endcase
            if (Cond == c_cond_nv) begin
                w_legal = 1'b0;
            end
            w_pass = cond_pass(Cond, r_flags);
        end
        w_illegal = ~w_legal;
        w_condex  = w_legal & w_pass;
        w_ctrl    = w_legal ? w_op : c_alu_add;
        w_fw      = w_legal ? (w_fw_raw & {2{w_pass}}) : c_fw_none;
    end

    // A conditional must not read NZCV while any writer is still in flight,
    // and a new writer cannot enter a full FIFO unless a retire frees a slot
    assign w_slot_free = ~r_out_valid | OUT_READY;
    assign w_hazard    = ((Cond != c_cond_al) & ALUOp & (w_fifo_count != '0))
                       | ((w_fw != c_fw_none) & w_fifo_full & ~FLAG_VALID);
    assign IN_READY    = w_slot_free & ~w_hazard;
    assign w_accept    = IN_VALID & IN_READY;
    assign w_push      = w_accept & (w_fw != c_fw_none);
    assign w_pop       = FLAG_VALID & ~w_fifo_empty;

    flag_fifo #(
        .DEPTH (DEPTH)
    ) u_flag_fifo (
        .clk     (CLK),
        .rst     (RESET),
        .i_push  (w_push),
        .i_wdata (w_fw),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    // Output pipeline register; holds while the execute stage is not ready
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_out_valid <= 1'b0;
            r_ctrl      <= '0;
            r_flagw     <= 2'b00;
            r_condex    <= 1'b0;
            r_illegal   <= 1'b0;
        end else if (w_slot_free) begin
            r_out_valid <= w_accept;
            if (w_accept) begin
                r_ctrl    <= CTRL_W'(w_ctrl);
                r_flagw   <= w_fw;
                r_condex  <= w_condex;
                r_illegal <= w_illegal;
            end
        end
    end

    // Architectural NZCV: retire the oldest writer's mask; flag a stray return
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_flags    <= 4'b0000;
            r_flag_err <= 1'b0;
        end else begin
            if (w_pop) begin
                if (w_fifo_head[1]) r_flags[3:2] <= ALUFlags[3:2];
                if (w_fifo_head[0]) r_flags[1:0] <= ALUFlags[1:0];
            end
            if (FLAG_VALID & w_fifo_empty) begin
                r_flag_err <= 1'b1;
            end
        end
    end

    assign OUT_VALID  = r_out_valid;
    assign ALUControl = r_ctrl;
    assign FlagW      = r_flagw;
    assign CondEx     = r_condex;
    assign ILLEGAL    = r_illegal;
    assign FLAGS      = r_flags;
    assign FLAG_ERR   = r_flag_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_ctrl_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_ctrl_scoreboard
// Description : Self-checking bench for alu_ctrl_scoreboard with a queue-
//               based reference model of the decoder and flag scoreboard.
// Revision    : 1.0  initial release
// ============================================================================
module tb_alu_ctrl_scoreboard;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [3:0] ctrl;
        logic [1:0] fw;
        logic       cx;
        logic       ill;
    } dec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid, aluop, out_ready, flag_valid;
    logic [4:0] funct;
    logic [1:0] shift;
    logic [3:0] cond, alu_flags;

    logic in_ready, out_valid, condex, illegal, flag_err;
    logic [3:0] ctrl, flags;
    logic [1:0] fw;
    logic in_ready_0, out_valid_0, condex_0, illegal_0, flag_err_0;
    logic [3:0] ctrl_0, flags_0;
    logic [1:0] fw_0;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    bit         m_ov;
    dec_t       m_out;
    logic [3:0] m_flags;
    bit         m_err;
    logic [1:0] m_q[$];

    logic [3:0] ops [7] = '{4'd4, 4'd2, 4'd10, 4'd0, 4'd12, 4'd13, 4'd1};

    always #5 clk = ~clk;

    alu_ctrl_scoreboard #(.DEPTH(DEPTH), .CTRL_W(4), .EXT_OPS(1)) dut (
        .CLK(clk), .RESET(rst), .IN_VALID(in_valid), .IN_READY(in_ready),
        .ALUOp(aluop), .FUNCT(funct), .ShiftType(shift), .Cond(cond),
        .OUT_VALID(out_valid), .OUT_READY(out_ready), .ALUControl(ctrl),
        .FlagW(fw), .CondEx(condex), .ILLEGAL(illegal), .FLAG_VALID(flag_valid),
        .ALUFlags(alu_flags), .FLAGS(flags), .FLAG_ERR(flag_err)
    );

    alu_ctrl_scoreboard #(.DEPTH(DEPTH), .CTRL_W(4), .EXT_OPS(0)) dut0 (
        .CLK(clk), .RESET(rst), .IN_VALID(in_valid), .IN_READY(in_ready_0),
        .ALUOp(aluop), .FUNCT(funct), .ShiftType(shift), .Cond(cond),
        .OUT_VALID(out_valid_0), .OUT_READY(out_ready), .ALUControl(ctrl_0),
        .FlagW(fw_0), .CondEx(condex_0), .ILLEGAL(illegal_0), .FLAG_VALID(flag_valid),
        .ALUFlags(alu_flags), .FLAGS(flags_0), .FLAG_ERR(flag_err_0)
    );

    // Decode as an ARM programmer would read the instruction table
    function automatic dec_t model_decode(input logic a, input logic [4:0] f, input logic [1:0] sh,
                                          input logic [3:0] cd, input logic [3:0] fl, input bit ext);
        dec_t d;
        bit ok, pass, s, n, z, c, v;
        logic [3:0] op;
        logic [1:0] wr;
        logic [3:0] shop [4] = '{4'd6, 4'd5, 4'd7, 4'd8};
        {n, z, c, v} = fl;
        s = f[0];
        if (!a) begin
            d.ctrl = 4'd0; d.fw = 2'b00; d.cx = 1'b1; d.ill = 1'b0;
            return d;
        end
        ok = 1; op = 4'd0; wr = 2'b00; pass = 0;
        case (f[4:1])
            4'd4:  begin op = 4'd0; wr = s ? 2'b11 : 2'b00; end
            4'd2:  begin op = 4'd1; wr = s ? 2'b11 : 2'b00; end
            4'd10: begin op = 4'd2; wr = 2'b11; end
            4'd0:  begin op = 4'd3; wr = s ? 2'b10 : 2'b00; end
            4'd12: begin op = 4'd4; wr = s ? 2'b10 : 2'b00; end
            4'd13: begin op = shop[sh]; wr = s ? 2'b10 : 2'b00; ok = ext || (sh < 2'd2); end
            4'd1:  begin op = 4'd9; wr = s ? 2'b10 : 2'b00; ok = ext; end
            default: ok = 0;
        endcase
        case (cd)
            4'd0: pass = z;          4'd1: pass = !z;
            4'd2: pass = c;          4'd3: pass = !c;
            4'd4: pass = n;          4'd5: pass = !n;
            4'd6: pass = v;          4'd7: pass = !v;
            4'd8: pass = c && !z;    4'd9: pass = !c || z;
            4'd10: pass = (n == v);  4'd11: pass = (n != v);
            4'd12: pass = !z && (n == v);
            4'd13: pass = z || (n != v);
            4'd14: pass = 1;
            default: begin pass = 0; ok = 0; end
        endcase
        if (!ok) begin
            d.ctrl = 4'd0; d.fw = 2'b00; d.cx = 1'b0; d.ill = 1'b1;
        end else begin
            d.ctrl = op; d.fw = pass ? wr : 2'b00; d.cx = pass; d.ill = 1'b0;
        end
        return d;
    endfunction

    function automatic bit model_ready();
        dec_t d;
        bit slot, hz;
        d    = model_decode(aluop, funct, shift, cond, m_flags, 1);
        slot = !m_ov || out_ready;
        hz   = (cond != 4'd14 && aluop && m_q.size() != 0) ||
               (d.fw != 2'b00 && m_q.size() == DEPTH && !flag_valid);
        return slot && !hz;
    endfunction

    // Advance one clock, updating the model from the inputs presented this cycle
    task automatic tick();
        dec_t d;
        bit rdy, slot;
        logic [1:0] h;
        d    = model_decode(aluop, funct, shift, cond, m_flags, 1);
        rdy  = model_ready();
        slot = !m_ov || out_ready;
        @(posedge clk);
        if (slot) begin
            m_ov = in_valid && rdy;
            if (in_valid && rdy) m_out = d;
        end
        if (flag_valid) begin
            if (m_q.size() != 0) begin
                h = m_q.pop_front();
                if (h[1]) m_flags[3:2] = alu_flags[3:2];
                if (h[0]) m_flags[1:0] = alu_flags[1:0];
            end else begin
                m_err = 1;
            end
        end
        if (in_valid && rdy && d.fw != 2'b00) m_q.push_back(d.fw);
        #1;
    endtask

    task automatic model_reset();
        m_ov = 0; m_out = '0; m_flags = 4'd0; m_err = 0;
        m_q.delete();
    endtask

    task automatic idle_inputs();
        in_valid = 0; aluop = 0; funct = 5'd0; shift = 2'd0; cond = 4'd14;
        out_ready = 1; flag_valid = 0; alu_flags = 4'd0;
    endtask

    task automatic set_instr(input logic a, input logic [4:0] f, input logic [1:0] sh, input logic [3:0] cd);
        in_valid = 1; aluop = a; funct = f; shift = sh; cond = cd;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 0;
        model_reset();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++; if (ctrl !== 4'd0) begin n_errors++; $display("FAIL reset_ctrl: got %h want 0", ctrl); end
        n_checks++; if (fw !== 2'b00) begin n_errors++; $display("FAIL reset_flagw: got %b want 00", fw); end
        n_checks++; if (condex !== 1'b0) begin n_errors++; $display("FAIL reset_condex: got %b want 0", condex); end
        n_checks++; if (illegal !== 1'b0) begin n_errors++; $display("FAIL reset_illegal: got %b want 0", illegal); end
        n_checks++; if (flags !== 4'd0) begin n_errors++; $display("FAIL reset_flags: got %b want 0000", flags); end
        n_checks++; if (flag_err !== 1'b0) begin n_errors++; $display("FAIL reset_flag_err: got %b want 0", flag_err); end
        rst = 0;
        model_reset();
    endtask

    task automatic test_adds();
        do_reset();
        set_instr(1, 5'b01001, 2'b00, 4'b1110);
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL adds_ready: got %b want 1", in_ready); end
        tick();
        in_valid = 0; #1;
        n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL adds_valid: got %b want 1", out_valid); end
        n_checks++; if (ctrl !== 4'b0000) begin n_errors++; $display("FAIL adds_ctrl: got %b want 0000", ctrl); end
        n_checks++; if (fw !== 2'b11) begin n_errors++; $display("FAIL adds_flagw: got %b want 11", fw); end
        n_checks++; if (condex !== 1'b1) begin n_errors++; $display("FAIL adds_condex: got %b want 1", condex); end
        // one writer in flight: a conditional must now stall
        set_instr(1, 5'b00000, 2'b00, 4'b0001);
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL adds_count1_stall: got %b want 0", in_ready); end
        idle_inputs();
    endtask

    task automatic test_cond(input logic [3:0] af, input logic s, input logic exp_cx);
        do_reset();
        set_instr(1, 5'b01001, 2'b00, 4'b1110);
        tick();
        set_instr(1, {4'b0000, s}, 2'b00, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL cond_stall[%0d]: got %b want 0", i, in_ready); end
            tick();
        end
        flag_valid = 1; alu_flags = af; #1;
        n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL cond_no_bypass: got %b want 0", in_ready); end
        tick();
        flag_valid = 0; #1;
        n_checks++; if (flags !== af) begin n_errors++; $display("FAIL cond_flags: got %b want %b", flags, af); end
        n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL cond_release: got %b want 1", in_ready); end
        tick();
        set_instr(1, 5'b00000, 2'b00, 4'b0001);
        #1;
        n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL cond_valid: got %b want 1", out_valid); end
        n_checks++; if (condex !== exp_cx) begin n_errors++; $display("FAIL cond_condex: got %b want %b", condex, exp_cx); end
        n_checks++; if (fw !== 2'b00) begin n_errors++; $display("FAIL cond_flagw: got %b want 00", fw); end
        n_checks++; if (ctrl !== 4'b0011) begin n_errors++; $display("FAIL cond_ctrl: got %b want 0011", ctrl); end
        // nothing was pushed, so a further conditional is not blocked
        n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL cond_no_push: got %b want 1", in_ready); end
        idle_inputs();
    endtask

    task automatic test_fifo_full();
        logic [3:0] v;
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            set_instr(1, 5'b10101, 2'b00, 4'b1110);
            #1;
            n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL full_fill[%0d]: got %b want 1", i, in_ready); end
            tick();
        end
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL full_stall: got %b want 0", in_ready); end
        tick();
        flag_valid = 1; alu_flags = 4'b0011; #1;
        n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL full_pop_push: got %b want 1", in_ready); end
        tick();
        flag_valid = 0; #1;
        n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL full_count_kept: got %b want 0", in_ready); end
        n_checks++; if (flags !== 4'b0011) begin n_errors++; $display("FAIL full_flags: got %b want 0011", flags); end
        in_valid = 0;
        for (int i = 0; i < DEPTH; i++) begin
            v = 4'($urandom_range(15, 0));
            flag_valid = 1; alu_flags = v;
            tick();
            n_checks++; if (flags !== v) begin n_errors++; $display("FAIL full_drain[%0d]: got %b want %b", i, flags, v); end
            n_checks++; if (flag_err !== 1'b0) begin n_errors++; $display("FAIL full_drain_err[%0d]: got %b want 0", i, flag_err); end
        end
        idle_inputs();
    endtask

    task automatic test_ext_ops();
        do_reset();
        set_instr(1, 5'b00010, 2'b00, 4'b1110);
        #1;
        n_checks++; if (in_ready_0 !== 1'b1) begin n_errors++; $display("FAIL ext0_ready: got %b want 1", in_ready_0); end
        tick();
        set_instr(1, 5'b11010, 2'b10, 4'b1110);
        #1;
        n_checks++; if (illegal_0 !== 1'b1) begin n_errors++; $display("FAIL ext0_eor_ill: got %b want 1", illegal_0); end
        n_checks++; if (ctrl_0 !== 4'd0) begin n_errors++; $display("FAIL ext0_eor_ctrl: got %h want 0", ctrl_0); end
        n_checks++; if (condex_0 !== 1'b0) begin n_errors++; $display("FAIL ext0_eor_cx: got %b want 0", condex_0); end
        n_checks++; if (out_valid_0 !== 1'b1) begin n_errors++; $display("FAIL ext0_eor_valid: got %b want 1", out_valid_0); end
        n_checks++; if (ctrl !== 4'b1001 || illegal !== 1'b0) begin n_errors++; $display("FAIL ext1_eor: got ctrl=%b ill=%b want 1001/0", ctrl, illegal); end
        tick();
        set_instr(1, 5'b01000, 2'b00, 4'b1111);
        #1;
        n_checks++; if (illegal_0 !== 1'b1 || ctrl_0 !== 4'd0) begin n_errors++; $display("FAIL ext0_asr: got ill=%b ctrl=%h want 1/0", illegal_0, ctrl_0); end
        n_checks++; if (ctrl !== 4'b0111 || illegal !== 1'b0) begin n_errors++; $display("FAIL ext1_asr: got ctrl=%b ill=%b want 0111/0", ctrl, illegal); end
        tick();
        in_valid = 0; #1;
        n_checks++; if (illegal_0 !== 1'b1 || condex_0 !== 1'b0) begin n_errors++; $display("FAIL ext0_nv: got ill=%b cx=%b want 1/0", illegal_0, condex_0); end
        n_checks++; if (illegal !== 1'b1 || condex !== 1'b0 || ctrl !== 4'd0 || fw !== 2'b00) begin n_errors++; $display("FAIL ext1_nv: got ill=%b cx=%b ctrl=%h fw=%b want 1/0/0/00", illegal, condex, ctrl, fw); end
        idle_inputs();
    endtask

    task automatic test_flag_err();
        do_reset();
        set_instr(1, 5'b01001, 2'b00, 4'b1110);
        tick();
        in_valid = 0; flag_valid = 1; alu_flags = 4'b1010;
        tick();
        n_checks++; if (flags !== 4'b1010 || flag_err !== 1'b0) begin n_errors++; $display("FAIL ferr_pre: got flags=%b err=%b want 1010/0", flags, flag_err); end
        alu_flags = 4'b0101;
        tick();
        flag_valid = 0; #1;
        n_checks++; if (flag_err !== 1'b1) begin n_errors++; $display("FAIL ferr_set: got %b want 1", flag_err); end
        n_checks++; if (flags !== 4'b1010) begin n_errors++; $display("FAIL ferr_flags_kept: got %b want 1010", flags); end
        tick(); tick();
        n_checks++; if (flag_err !== 1'b1) begin n_errors++; $display("FAIL ferr_sticky: got %b want 1", flag_err); end
        idle_inputs();
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        set_instr(1, 5'b01001, 2'b00, 4'b1110);
        tick();
        in_valid = 0; flag_valid = 1; alu_flags = 4'b1111;
        tick(); tick();
        flag_valid = 0;
        set_instr(1, 5'b11001, 2'b00, 4'b1110);
        tick();
        set_instr(1, 5'b00001, 2'b00, 4'b0000);
        out_ready = 0;
        tick(); tick();
        n_checks++; if (out_valid !== 1'b1 || flags !== 4'b1111 || flag_err !== 1'b1 || in_ready !== 1'b0) begin
            n_errors++; $display("FAIL rstmid_pre: got v=%b flags=%b err=%b rdy=%b want 1/1111/1/0", out_valid, flags, flag_err, in_ready);
        end
        #2; rst = 1; #1;
        n_checks++; if (out_valid !== 1'b0 || ctrl !== 4'd0 || fw !== 2'b00 || condex !== 1'b0 || illegal !== 1'b0) begin
            n_errors++; $display("FAIL rstmid_out: got v=%b ctrl=%h fw=%b cx=%b ill=%b want all 0", out_valid, ctrl, fw, condex, illegal);
        end
        n_checks++; if (flags !== 4'd0 || flag_err !== 1'b0) begin n_errors++; $display("FAIL rstmid_flags: got flags=%b err=%b want 0000/0", flags, flag_err); end
        rst = 0;
        model_reset();
        out_ready = 1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL rstmid_fifo_cleared: got %b want 1", in_ready); end
        idle_inputs();
        tick();
    endtask

    task automatic test_random();
        logic [3:0] op;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(3, 0) != 0);
            aluop     = ($urandom_range(9, 0) != 0);
            op        = ($urandom_range(9, 0) == 0) ? 4'($urandom_range(15, 0)) : ops[$urandom_range(6, 0)];
            funct     = {op, 1'($urandom_range(1, 0))};
            shift     = 2'($urandom_range(3, 0));
            cond      = ($urandom_range(1, 0) != 0) ? 4'd14 : 4'($urandom_range(15, 0));
            out_ready = ($urandom_range(3, 0) != 0);
            flag_valid = (m_q.size() != 0) ? ($urandom_range(2, 0) == 0) : ($urandom_range(49, 0) == 0);
            alu_flags = 4'($urandom_range(15, 0));
            #1;
            n_checks++; if (in_ready !== model_ready()) begin n_errors++; $display("FAIL rnd_ready[%0d]: got %b want %b", i, in_ready, model_ready()); end
            n_checks++; if (out_valid !== m_ov) begin n_errors++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, out_valid, m_ov); end
            if (m_ov) begin
                n_checks++; if ({ctrl, fw, condex, illegal} !== m_out) begin
                    n_errors++; $display("FAIL rnd_result[%0d]: got ctrl=%b fw=%b cx=%b ill=%b want ctrl=%b fw=%b cx=%b ill=%b",
                                         i, ctrl, fw, condex, illegal, m_out.ctrl, m_out.fw, m_out.cx, m_out.ill);
                end
            end
            n_checks++; if (flags !== m_flags) begin n_errors++; $display("FAIL rnd_flags[%0d]: got %b want %b", i, flags, m_flags); end
            n_checks++; if (flag_err !== m_err) begin n_errors++; $display("FAIL rnd_flag_err[%0d]: got %b want %b", i, flag_err, m_err); end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_adds();
        test_cond(4'b0100, 1'b0, 1'b1);
        test_cond(4'b0000, 1'b1, 1'b0);
        test_fifo_full();
        test_ext_ops();
        test_flag_err();
        test_reset_mid_stall();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
